alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 26 ++
 rtl/alu_exec_unit_comb.sv | 37 +++
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 tb/tb_alu_exec_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared opcodes, FSM encoding and helpers
// for the execution-stage ALU.
package alu_exec_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU ops; shifts are legal here
// but produce no result (handled by the FSM).
module alu_comb_core
    import alu_exec_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int ALUOP = 4
) (
    input  logic [ALUOP-1:0] i_ALUOp,
    input  logic [NBITS-1:0] i_A,
    input  logic [NBITS-1:0] i_B,
    output logic [NBITS-1:0] o_Result,
    output logic             o_Illegal
);

    logic w_lt;

    assign w_lt = $signed(i_A) < $signed(i_B);

    // Result mux; unknown codes flag illegal and give zero
    always_comb begin
        o_Result  = '0;
        o_Illegal = 1'b0;
        unique case (i_ALUOp)
            OP_AND: o_Result = i_A & i_B;
            OP_OR:  o_Result = i_A | i_B;
            OP_ADD: o_Result = i_A + i_B;
            OP_SUB: o_Result = i_A - i_B;
            OP_SLT: o_Result = {{(NBITS-1){1'b0}}, w_lt};
            OP_NOR: o_Result = ~(i_A | i_B);
            OP_XOR: o_Result = i_A ^ i_B;
            OP_SLL, OP_SRL, OP_SRA: o_Result = '0;
            default: o_Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready on both
// sides; shifts iterate one bit per cycle.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int SHAMTBITS = 5,
    parameter int ALUOP     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [ALUOP-1:0]     i_ALUOp,
    input  logic [NBITS-1:0]     i_A,
    input  logic [NBITS-1:0]     i_B,
    input  logic [SHAMTBITS-1:0] i_Shamt,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NBITS-1:0]     o_Result,
    output logic                 o_Zero,
    output logic                 o_Error
);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_valid;
    logic [NBITS-1:0]     r_result;
    logic                 r_zero;
    logic                 r_error;
    logic [NBITS-1:0]     r_shreg;
    logic [SHAMTBITS-1:0] r_count;
    logic [ALUOP-1:0]     r_op;

    logic [NBITS-1:0]     w_comb;
    logic                 w_illegal;
    logic [NBITS-1:0]     w_shnext;
    logic                 w_shift_req;

    alu_comb_core #(
        .NBITS (NBITS),
        .ALUOP (ALUOP)
    ) u_core (
        .i_ALUOp   (i_ALUOp),
        .i_A       (i_A),
        .i_B       (i_B),
        .o_Result  (w_comb),
        .o_Illegal (w_illegal)
    );

    assign w_shift_req = is_shift(i_ALUOp);

    // One-bit step of the pending shift
    always_comb begin
        w_shnext = r_shreg;
        unique case (r_op)
            OP_SLL:  w_shnext = {r_shreg[NBITS-2:0], 1'b0};
            OP_SRL:  w_shnext = {1'b0, r_shreg[NBITS-1:1]};
            OP_SRA:  w_shnext = {r_shreg[NBITS-1], r_shreg[NBITS-1:1]};
            default: w_shnext = r_shreg;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_error  <= 1'b0;
            r_shreg  <= '0;
            r_count  <= '0;
            r_op     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_ready <= 1'b0;
                        if (w_shift_req && (i_Shamt != '0)) begin
                            r_shreg <= i_B;
                            r_count <= i_Shamt;
                            r_op    <= i_ALUOp;
                            r_state <= ST_SHIFT;
                        end else if (w_shift_req) begin
                            r_result <= i_B;
                            r_zero   <= (i_B == '0);
                            r_error  <= 1'b0;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_result <= w_comb;
                            r_zero   <= (w_comb == '0);
                            r_error  <= w_illegal;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= w_shnext;
                    r_count <= r_count - 1'b1;
                    if (r_count == SHAMTBITS'(1)) begin
                        r_result <= w_shnext;
                        r_zero   <= (w_shnext == '0);
                        r_error  <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_Result = r_result;
    assign o_Zero   = r_zero;
    assign o_Error  = r_error;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        vin;
    logic        rdy_o;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        vout;
    logic        rdy_i;
    logic [31:0] res;
    logic        zero;
    logic        err;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy;
    int seen;

    alu_exec_unit #(
        .NBITS     (32),
        .SHAMTBITS (5),
        .ALUOP     (4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (vin),
        .o_ready  (rdy_o),
        .i_ALUOp  (op),
        .i_A      (a),
        .i_B      (b),
        .i_Shamt  (sh),
        .o_valid  (vout),
        .i_ready  (rdy_i),
        .o_Result (res),
        .o_Zero   (zero),
        .o_Error  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, return at the negedge where o_valid
    // is first seen (or after the cycle budget), with latency in cycles.
    task automatic run_op(input logic [3:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [4:0] s,
                          output int l, output int bz);
        op = o; a = aa; b = bb; sh = s; vin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin = 1'b0;
        op = 4'hE; a = 32'hDEAD_BEEF; b = 32'h1234_5678; sh = 5'd7;
        l = 1;
        bz = 0;
        while (!vout && l < 200) begin
            if (!rdy_o) bz++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic retire();
        rdy_i = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; rdy_i = 1'b1;
        op = '0; a = '0; b = '0; sh = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(rdy_o), 32'd1);
        chk("rst_valid", 32'(vout), 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_error", 32'(err), 32'd0);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, lat, busy);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_res", res, 32'h8000_0000);
        chk("add_zero", 32'(zero), 32'd0);
        chk("add_err", 32'(err), 32'd0);
        retire();
        chk("add_back_ready", 32'(rdy_o), 32'd1);

        run_op(4'b0110, 32'd5, 32'd5, 5'd0, lat, busy);
        chk("sub_res", res, 32'd0);
        chk("sub_zero", 32'(zero), 32'd1);
        retire();

        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, busy);
        chk("slt_res", res, 32'd1);
        chk("slt_zero", 32'(zero), 32'd0);
        retire();

        run_op(4'b0101, 32'd0, 32'h8000_0010, 5'd4, lat, busy);
        chk("sra_lat", 32'(lat), 32'd5);
        chk("sra_busy", 32'(busy), 32'd4);
        chk("sra_res", res, 32'hF800_0001);
        retire();

        run_op(4'b0011, 32'd0, 32'd1, 5'd0, lat, busy);
        chk("sll0_lat", 32'(lat), 32'd1);
        chk("sll0_res", res, 32'd1);
        retire();

        run_op(4'b0011, 32'd0, 32'd1, 5'd31, lat, busy);
        chk("sll31_lat", 32'(lat), 32'd32);
        chk("sll31_res", res, 32'h8000_0000);
        retire();

        run_op(4'b0100, 32'd0, 32'h8000_0000, 5'd31, lat, busy);
        chk("srl31_res", res, 32'd1);
        retire();

        rdy_i = 1'b0;
        run_op(4'b1101, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, lat, busy);
        chk("xor_res", res, 32'h0F0F_F0F0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("xor_hold_valid", 32'(vout), 32'd1);
            chk("xor_hold_res", res, 32'h0F0F_F0F0);
        end
        rdy_i = 1'b1;
        @(negedge clk);
        chk("xor_drop_valid", 32'(vout), 32'd0);
        chk("xor_drop_ready", 32'(rdy_o), 32'd1);

        run_op(4'b1100, 32'h0000_FFFF, 32'h00FF_0000, 5'd0, lat, busy);
        chk("nor_res", res, 32'hFF00_0000);
        retire();

        run_op(4'b1111, 32'd3, 32'd4, 5'd0, lat, busy);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_res", res, 32'd0);
        chk("ill_zero", 32'(zero), 32'd1);
        retire();

        op = 4'b0100; a = '0; b = 32'hFFFF_FFFF; sh = 5'd10; vin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(rdy_o), 32'd1);
        chk("abort_valid", 32'(vout), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (vout) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);

        run_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, lat, busy);
        chk("and_res", res, 32'h0F00_0F00);
        chk("and_err", 32'(err), 32'd0);
        retire();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
